// File: rtl/descriptor_batch_assembler.sv
// rtl/descriptor_batch_assembler.sv - keypoint window reader, band histogram accumulator and descriptor batcher
module descriptor_batch_assembler #(
  parameter int BATCH         = 4,
  parameter int KPT_W         = 20,
  parameter int ROW_W         = 9,
  parameter int COL_W         = 10,
  parameter int IMG_ROWS      = 480,
  parameter int BIN_W         = 12,
  parameter int ROWS_PER_BAND = 8,
  parameter int NBANDS        = 2,
  parameter int ADDR_W        = 11,
  parameter int HIST_W        = 8 * BIN_W,
  parameter int DESC_W        = (KPT_W - 1) + NBANDS * 2 * HIST_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       kpt_num,
  output logic [ADDR_W-1:0]       kpt_addr,
  input  logic [KPT_W-1:0]        kpt_data,
  output logic [ROW_W-1:0]        blurred_addr,
  output logic                    lb_we,
  output logic                    lb_layer,
  output logic [ROW_W-1:0]        center_row,
  output logic [COL_W-1:0]        center_col,
  input  logic                    hist_valid,
  input  logic [HIST_W-1:0]       hist_a,
  input  logic [HIST_W-1:0]       hist_b,
  output logic [BATCH*DESC_W-1:0] desc_data,
  output logic [BATCH-1:0]        desc_mask,
  output logic                    desc_valid,
  input  logic                    desc_ready,
  output logic                    desc_last,
  output logic                    busy,
  output logic                    done
);

  localparam int WIN     = ROWS_PER_BAND * NBANDS;
  localparam int CNT_W   = $clog2(WIN + 1);
  localparam int SLOT_W  = $clog2(BATCH + 1);
  // {row,col} sits directly above all band histograms in a slot
  localparam int BANDS_W = NBANDS * 2 * HIST_W;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_ROWS, S_DRAIN, S_STORE, S_EMIT, S_DONE
  } state_t;

  state_t state, state_n;

  logic [ADDR_W-1:0] kpt_total;
  logic [SLOT_W-1:0] slot;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  ret_cnt;
  logic [CNT_W-1:0]  band_row;
  logic [CNT_W-1:0]  band_idx;
  logic [HIST_W-1:0] acc_a, acc_b;
  logic [HIST_W-1:0] base_a, base_b;
  logic [HIST_W-1:0] sum_a, sum_b;
  logic [ROW_W-1:0]  kpt_row;
  logic [COL_W-1:0]  kpt_col;
  logic [ROW_W-1:0]  win_start;
  logic [ADDR_W-1:0] addr_inc;
  logic [SLOT_W-1:0] slot_inc;
  logic              take_ret;
  logic              rets_done;
  logic              last_issue;
  logic              band_end;

  function automatic logic [BIN_W-1:0] sat_add(input logic [BIN_W-1:0] x, input logic [BIN_W-1:0] y);
    logic [BIN_W:0] s;
    s = {1'b0, x} + {1'b0, y};
    return s[BIN_W] ? {BIN_W{1'b1}} : s[BIN_W-1:0];
  endfunction

  assign kpt_row    = kpt_data[KPT_W-2 -: ROW_W];
  assign kpt_col    = kpt_data[COL_W-1:0];
  assign addr_inc   = kpt_addr + ADDR_W'(1);
  assign slot_inc   = slot + SLOT_W'(1);
  assign last_issue = (issue_cnt == CNT_W'(WIN - 1));
  assign band_end   = (band_row == CNT_W'(ROWS_PER_BAND - 1));
  // returns are only meaningful while a window is outstanding
  assign take_ret   = hist_valid && ((state == S_ROWS) || (state == S_DRAIN)) &&
                      (ret_cnt != CNT_W'(WIN));
  assign rets_done  = (ret_cnt == CNT_W'(WIN)) || (take_ret && (ret_cnt == CNT_W'(WIN - 1)));

  assign desc_valid = (state == S_EMIT);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  // window start row: centred on the keypoint, pulled inside the image at both edges
  always_comb begin
    win_start = kpt_row - ROW_W'(WIN / 2);
    if (kpt_row < ROW_W'(WIN / 2)) begin
      win_start = '0;
    end else if (({1'b0, kpt_row} + (ROW_W+1)'(WIN / 2)) > (ROW_W+1)'(IMG_ROWS)) begin
      win_start = ROW_W'(IMG_ROWS - WIN);
    end
  end

  // per-lane saturating sum; the first row of a band starts from zero
  always_comb begin
    base_a = (band_row == '0) ? '0 : acc_a;
    base_b = (band_row == '0) ? '0 : acc_b;
    sum_a  = '0;
    sum_b  = '0;
    for (int i = 0; i < 8; i++) begin
      sum_a[i*BIN_W +: BIN_W] = sat_add(base_a[i*BIN_W +: BIN_W], hist_a[i*BIN_W +: BIN_W]);
      sum_b[i*BIN_W +: BIN_W] = sat_add(base_b[i*BIN_W +: BIN_W], hist_b[i*BIN_W +: BIN_W]);
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = (kpt_num == '0) ? S_DONE : S_FETCH;
      S_FETCH: state_n = S_LATCH;
      S_LATCH: state_n = S_ROWS;
      S_ROWS:  if (last_issue) state_n = rets_done ? S_STORE : S_DRAIN;
      S_DRAIN: if (rets_done) state_n = S_STORE;
      S_STORE: state_n = ((slot_inc == SLOT_W'(BATCH)) || (addr_inc == kpt_total)) ? S_EMIT : S_FETCH;
      S_EMIT:  if (desc_ready) state_n = desc_last ? S_DONE : S_FETCH;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // datapath: keypoint capture, row issue, band accumulation and slot packing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kpt_addr     <= '0;
      kpt_total    <= '0;
      slot         <= '0;
      blurred_addr <= '0;
      lb_we        <= 1'b0;
      lb_layer     <= 1'b0;
      center_row   <= '0;
      center_col   <= '0;
      desc_data    <= '0;
      desc_mask    <= '0;
      desc_last    <= 1'b0;
      issue_cnt    <= '0;
      ret_cnt      <= '0;
      band_row     <= '0;
      band_idx     <= '0;
      acc_a        <= '0;
      acc_b        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            kpt_total <= kpt_num;
            kpt_addr  <= '0;
            slot      <= '0;
            desc_data <= '0;
            desc_mask <= '0;
            desc_last <= 1'b0;
          end
        end
        S_LATCH: begin
          center_row   <= kpt_row;
          center_col   <= kpt_col;
          lb_layer     <= kpt_data[KPT_W-1];
          blurred_addr <= win_start;
          lb_we        <= 1'b1;
          issue_cnt    <= '0;
          ret_cnt      <= '0;
          band_row     <= '0;
          band_idx     <= '0;
        end
        S_ROWS: begin
          if (last_issue) begin
            lb_we <= 1'b0;
          end else begin
            blurred_addr <= blurred_addr + ROW_W'(1);
            issue_cnt    <= issue_cnt + CNT_W'(1);
          end
        end
        S_STORE: begin
          for (int k = 0; k < BATCH; k++) begin
            if (slot == SLOT_W'(k)) begin
              desc_data[k*DESC_W + BANDS_W +: KPT_W-1] <= {center_row, center_col};
            end
          end
          desc_mask <= desc_mask | (BATCH'(1) << slot);
          kpt_addr  <= addr_inc;
          slot      <= slot_inc;
          desc_last <= (addr_inc == kpt_total);
        end
        S_EMIT: begin
          if (desc_ready) begin
            desc_data <= '0;
            desc_mask <= '0;
            desc_last <= 1'b0;
            slot      <= '0;
          end
        end
        default: ;
      endcase

      if (take_ret) begin
        acc_a   <= sum_a;
        acc_b   <= sum_b;
        ret_cnt <= ret_cnt + CNT_W'(1);
        if (band_end) begin
          band_row <= '0;
          band_idx <= band_idx + CNT_W'(1);
          for (int k = 0; k < BATCH; k++) begin
            for (int b = 0; b < NBANDS; b++) begin
              if ((slot == SLOT_W'(k)) && (band_idx == CNT_W'(b))) begin
                desc_data[k*DESC_W + (2*(NBANDS-1-b)+1)*HIST_W +: HIST_W] <= sum_a;
                desc_data[k*DESC_W + (2*(NBANDS-1-b))*HIST_W   +: HIST_W] <= sum_b;
              end
            end
          end
        end else begin
          band_row <= band_row + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_descriptor_batch_assembler.sv
// tb/tb_descriptor_batch_assembler.sv - randomized self-checking bench with a behavioural descriptor model
module tb_descriptor_batch_assembler;

  localparam int BATCH    = 4;
  localparam int KPT_W    = 20;
  localparam int ROW_W    = 9;
  localparam int COL_W    = 10;
  localparam int IMG_ROWS = 480;
  localparam int BIN_W    = 12;
  localparam int RPB      = 8;
  localparam int NBANDS   = 2;
  localparam int ADDR_W   = 11;
  localparam int HIST_W   = 8 * BIN_W;
  localparam int DESC_W   = (KPT_W - 1) + NBANDS * 2 * HIST_W;
  localparam int WIN      = RPB * NBANDS;
  localparam int BINMAX   = (1 << BIN_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic [ADDR_W-1:0]       kpt_num = '0;
  logic [ADDR_W-1:0]       kpt_addr;
  logic [KPT_W-1:0]        kpt_data;
  logic [ROW_W-1:0]        blurred_addr;
  logic                    lb_we;
  logic                    lb_layer;
  logic [ROW_W-1:0]        center_row;
  logic [COL_W-1:0]        center_col;
  logic                    hist_valid;
  logic [HIST_W-1:0]       hist_a, hist_b;
  logic [BATCH*DESC_W-1:0] desc_data;
  logic [BATCH-1:0]        desc_mask;
  logic                    desc_valid;
  logic                    desc_ready = 1'b0;
  logic                    desc_last;
  logic                    busy;
  logic                    done;

  always #5 clk = ~clk;

  descriptor_batch_assembler #(
    .BATCH(BATCH), .KPT_W(KPT_W), .ROW_W(ROW_W), .COL_W(COL_W), .IMG_ROWS(IMG_ROWS),
    .BIN_W(BIN_W), .ROWS_PER_BAND(RPB), .NBANDS(NBANDS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kpt_num(kpt_num), .kpt_addr(kpt_addr),
    .kpt_data(kpt_data), .blurred_addr(blurred_addr), .lb_we(lb_we), .lb_layer(lb_layer),
    .center_row(center_row), .center_col(center_col), .hist_valid(hist_valid),
    .hist_a(hist_a), .hist_b(hist_b), .desc_data(desc_data), .desc_mask(desc_mask),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_last(desc_last),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hmode = 0;
  int lat_min = 1;
  int lat_max = 1;

  logic [KPT_W-1:0] kmem [0:(1<<ADDR_W)-1];

  typedef struct { int due; logic [HIST_W-1:0] a; logic [HIST_W-1:0] b; } ret_t;
  typedef struct { int addr; int layer; int crow; int ccol; } iss_t;
  ret_t pend[$];
  logic [HIST_W-1:0] ref_a[$];
  logic [HIST_W-1:0] ref_b[$];
  iss_t iss_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_desc(input string tag, input logic [DESC_W-1:0] obs, input logic [DESC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [HIST_W-1:0] gen_hist();
    logic [HIST_W-1:0] h;
    h = '0;
    for (int i = 0; i < 8; i++) begin
      case (hmode)
        0:       h[i*BIN_W +: BIN_W] = BIN_W'(1);
        1:       h[i*BIN_W +: BIN_W] = BIN_W'(12'h3FF);
        default: h[i*BIN_W +: BIN_W] = BIN_W'($urandom_range(0, 700));
      endcase
    end
    return h;
  endfunction

  function automatic int exp_start(input int row);
    if (row < WIN / 2) return 0;
    if (row - WIN / 2 + WIN > IMG_ROWS) return IMG_ROWS - WIN;
    return row - WIN / 2;
  endfunction

  // descriptor j of the current run: band lane = min(max, sum of that band's rows)
  function automatic logic [DESC_W-1:0] exp_desc(input int j);
    logic [DESC_W-1:0] d;
    logic [KPT_W-1:0]  w;
    logic [HIST_W-1:0] h;
    int s, idx;
    w = kmem[j];
    d = '0;
    d[KPT_W-2:0] = w[KPT_W-2:0];
    for (int b = 0; b < NBANDS; b++) begin
      for (int hf = 0; hf < 2; hf++) begin
        d = d << HIST_W;
        for (int ln = 0; ln < 8; ln++) begin
          s = 0;
          for (int r = 0; r < RPB; r++) begin
            idx = j * WIN + b * RPB + r;
            if (idx < ref_a.size()) begin
              h = (hf == 0) ? ref_a[idx] : ref_b[idx];
              s += int'(h[ln*BIN_W +: BIN_W]);
            end
          end
          if (s > BINMAX) s = BINMAX;
          d[ln*BIN_W +: BIN_W] = BIN_W'(s);
        end
      end
    end
    return d;
  endfunction

  function automatic void set_kp(input int j, input int layer, input int row, input int col);
    kmem[j] = {1'(layer), ROW_W'(row), COL_W'(col)};
  endfunction

  function automatic void rand_kps(input int n);
    for (int j = 0; j < n; j++)
      set_kp(j, $urandom_range(0, 1), $urandom_range(0, IMG_ROWS - 1), $urandom_range(0, 1023));
  endfunction

  task automatic chk_row(input string tag, input int idx, input int exp);
    if (idx < iss_q.size()) chk(tag, 64'(iss_q[idx].addr), 64'(exp));
    else chk(tag, 64'hDEAD, 64'(exp));
  endtask

  // keypoint memory with one cycle read latency, and the histogram unit
  initial begin
    logic [ADDR_W-1:0] prev_addr;
    ret_t r;
    iss_t e;
    prev_addr = '0;
    hist_valid = 1'b0;
    hist_a = '0;
    hist_b = '0;
    kpt_data = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      kpt_data = kmem[prev_addr];
      prev_addr = kpt_addr;
      if (!rst_n) pend.delete();
      if (lb_we === 1'b1) begin
        r.due = cyc + $urandom_range(lat_min, lat_max);
        r.a = gen_hist();
        r.b = gen_hist();
        pend.push_back(r);
        ref_a.push_back(r.a);
        ref_b.push_back(r.b);
        e.addr = int'(blurred_addr);
        e.layer = int'(lb_layer);
        e.crow = int'(center_row);
        e.ccol = int'(center_col);
        iss_q.push_back(e);
      end
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        hist_valid = 1'b1;
        hist_a = pend[0].a;
        hist_b = pend[0].b;
        void'(pend.pop_front());
      end else begin
        hist_valid = 1'b0;
        hist_a = HIST_W'({$urandom, $urandom, $urandom});
        hist_b = HIST_W'({$urandom, $urandom, $urandom});
      end
    end
  end

  task automatic run_kpts(input string name, input int n, input int stall);
    int kp, guard, cnt, nb, bad, s, idx;
    bit fin, stable;
    logic [BATCH*DESC_W-1:0] held;
    logic [BATCH-1:0] mheld;
    logic [ADDR_W-1:0] a0;
    logic [KPT_W-1:0] w;
    iss_q.delete();
    ref_a.delete();
    ref_b.delete();
    kp = 0; guard = 0; fin = 0; nb = 0;
    kpt_num = ADDR_W'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_busy"}, 64'(busy), 64'd1);
    while (!fin && guard < 5000) begin
      guard++;
      if (desc_valid === 1'b1) begin
        if (stall > 0) begin
          held = desc_data; mheld = desc_mask; a0 = kpt_addr; stable = 1;
          repeat (stall) begin
            tick();
            if (desc_data !== held || desc_mask !== mheld || desc_valid !== 1'b1 ||
                lb_we !== 1'b0 || kpt_addr !== a0) stable = 0;
          end
          chk($sformatf("%s_b%0d_hold", name, nb), 64'(stable), 64'd1);
        end
        cnt = (n - kp < BATCH) ? n - kp : BATCH;
        chk($sformatf("%s_b%0d_mask", name, nb), 64'(desc_mask), 64'((1 << cnt) - 1));
        chk($sformatf("%s_b%0d_last", name, nb), 64'(desc_last), 64'(kp + cnt == n));
        for (int k = 0; k < BATCH; k++)
          chk_desc($sformatf("%s_b%0d_slot%0d", name, nb, k), desc_data[k*DESC_W +: DESC_W],
                   (k < cnt) ? exp_desc(kp + k) : '0);
        desc_ready = 1'b1;
        tick();
        desc_ready = 1'b0;
        chk($sformatf("%s_b%0d_valid_fall", name, nb), 64'(desc_valid), 64'd0);
        kp += cnt;
        nb++;
        if (kp >= n) begin
          chk({name, "_done_pulse"}, 64'(done), 64'd1);
          tick();
          chk({name, "_done_end"}, 64'(done), 64'd0);
          chk({name, "_idle"}, 64'(busy), 64'd0);
          fin = 1;
        end
      end else begin
        tick();
      end
    end
    chk({name, "_finished"}, 64'(fin), 64'd1);
    chk({name, "_nbatch"}, 64'(nb), 64'((n + BATCH - 1) / BATCH));
    chk({name, "_issues"}, 64'(iss_q.size()), 64'(n * WIN));
    for (int j = 0; j < n; j++) begin
      bad = 0;
      w = kmem[j];
      s = exp_start(int'(w[KPT_W-2 -: ROW_W]));
      for (int i = 0; i < WIN; i++) begin
        idx = j * WIN + i;
        if (idx >= iss_q.size()) bad++;
        else if (iss_q[idx].addr != s + i || iss_q[idx].layer != int'(w[KPT_W-1]) ||
                 iss_q[idx].crow != int'(w[KPT_W-2 -: ROW_W]) ||
                 iss_q[idx].ccol != int'(w[COL_W-1:0])) bad++;
      end
      chk($sformatf("%s_kp%0d_rows", name, j), 64'(bad), 64'd0);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_kpt_addr"}, 64'(kpt_addr), 64'd0);
    chk({name, "_blurred_addr"}, 64'(blurred_addr), 64'd0);
    chk({name, "_lb_we"}, 64'(lb_we), 64'd0);
    chk({name, "_lb_layer"}, 64'(lb_layer), 64'd0);
    chk({name, "_center"}, 64'({center_row, center_col}), 64'd0);
    chk({name, "_desc_data_or"}, 64'(|desc_data), 64'd0);
    chk({name, "_desc_mask"}, 64'(desc_mask), 64'd0);
    chk({name, "_desc_valid"}, 64'(desc_valid), 64'd0);
    chk({name, "_desc_last"}, 64'(desc_last), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    int guard;
    bit seen_we;
    for (int i = 0; i < (1 << ADDR_W); i++) kmem[i] = '0;

    // reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    tick();

    // single keypoint, unit histograms, fixed two-cycle latency
    set_kp(0, 1, 100, 200);
    hmode = 0; lat_min = 2; lat_max = 2;
    run_kpts("single", 1, 0);
    chk_row("single_first_row", 0, 92);
    chk_row("single_last_row", WIN - 1, 107);
    chk("single_lane_value", 64'(exp_desc(0) & DESC_W'(12'hFFF)), 64'd8);

    // saturation of band lanes
    hmode = 1; lat_min = 1; lat_max = 3;
    run_kpts("sat", 1, 0);

    // window clamping at the top and bottom of the image
    set_kp(0, 0, 3, 17);
    set_kp(1, 1, 475, 1000);
    hmode = 2; lat_min = 1; lat_max = 4;
    run_kpts("clamp", 2, 0);
    chk_row("clamp_top_first", 0, 0);
    chk_row("clamp_top_last", WIN - 1, 15);
    chk_row("clamp_bot_first", WIN, 464);
    chk_row("clamp_bot_last", 2 * WIN - 1, 479);

    // partial final batch
    rand_kps(6);
    hmode = 2; lat_min = 1; lat_max = 5;
    run_kpts("partial", 6, 0);

    // backpressure held in EMIT
    rand_kps(5);
    run_kpts("bp", 5, 10);

    // randomized longer run
    rand_kps(9);
    hmode = $urandom_range(1, 2); lat_min = 1; lat_max = 8;
    run_kpts("rnd", 9, 3);

    // zero keypoints
    kpt_num = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_no_valid", 64'(desc_valid), 64'd0);
    chk("zero_no_we", 64'(lb_we), 64'd0);
    tick();
    chk("zero_done_end", 64'(done), 64'd0);
    chk("zero_idle", 64'(busy), 64'd0);

    // reset while rows are being issued
    rand_kps(3);
    hmode = 2; lat_min = 1; lat_max = 3;
    kpt_num = ADDR_W'(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    seen_we = 0;
    while (!seen_we && guard < 50) begin
      guard++;
      if (lb_we === 1'b1) seen_we = 1;
      else tick();
    end
    chk("midrst_reached_rows", 64'(seen_we), 64'd1);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_idle", 64'(busy), 64'd0);

    // recovery after reset
    rand_kps(2);
    run_kpts("post", 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule
